// File: rtl/entry_checker.sv
// Entry-gate admission: opens the barrier when a car is waiting and a space is free,
// flags refused requests, and keeps saturating grant/deny arrival counts.
module entry_checker #(
    parameter int CAP_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             entry,
    input  logic [CAP_W-1:0] parking_capacity,
    output logic             enable,
    output logic             denied,
    output logic [CNT_W-1:0] grant_count,
    output logic [CNT_W-1:0] deny_count
);

    logic       has_space;
    logic       arrival;
    logic       entry_q_reg;
    logic       enable_reg;
    logic       denied_reg;
    logic [1:0] bump;

    assign has_space = (parking_capacity != '0);
    // A held request is one arrival; only its first cycle counts.
    assign arrival   = entry & ~entry_q_reg;
    assign bump[0]   = arrival & has_space;
    assign bump[1]   = arrival & ~has_space;

    always_ff @(posedge clk) begin
        if (rst) begin
            entry_q_reg <= 1'b0;
            enable_reg  <= 1'b0;
            denied_reg  <= 1'b0;
        end else begin
            entry_q_reg <= entry;
            enable_reg  <= entry & has_space;
            denied_reg  <= entry & ~has_space;
        end
    end

    // Index 0 counts granted arrivals, index 1 denied ones; both stick at all-ones.
    for (genvar gi = 0; gi < 2; gi++) begin : gen_cnt
        logic [CNT_W-1:0] cnt_reg;
        logic [CNT_W-1:0] cnt_next;

        always_comb begin
            cnt_next = cnt_reg;
            if (bump[gi] && (cnt_reg != '1)) begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_next;
            end
        end
    end

    assign enable      = enable_reg;
    assign denied      = denied_reg;
    assign grant_count = gen_cnt[0].cnt_reg;
    assign deny_count  = gen_cnt[1].cnt_reg;

endmodule

// File: tb/tb_entry_checker.sv
// Directed bench for entry_checker: a vector table for the gate/counter behaviour
// plus a hand-written saturation run on a narrow-counter instance.
module tb_entry_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        entry;
    logic [7:0]  parking_capacity;
    logic        enable;
    logic        denied;
    logic [15:0] grant_count;
    logic [15:0] deny_count;
    logic        s_enable;
    logic        s_denied;
    logic [3:0]  s_grant_count;
    logic [3:0]  s_deny_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    entry_checker #(.CAP_W(8), .CNT_W(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .entry            (entry),
        .parking_capacity (parking_capacity),
        .enable           (enable),
        .denied           (denied),
        .grant_count      (grant_count),
        .deny_count       (deny_count)
    );

    entry_checker #(.CAP_W(8), .CNT_W(4)) dut_sat (
        .clk              (clk),
        .rst              (rst),
        .entry            (entry),
        .parking_capacity (parking_capacity),
        .enable           (s_enable),
        .denied           (s_denied),
        .grant_count      (s_grant_count),
        .deny_count       (s_deny_count)
    );

    typedef struct {
        logic       rst;
        logic       entry;
        logic [7:0] cap;
        logic       en;
        logic       den;
        int         grant;
        int         deny;
    } vec_t;

    vec_t vq[$];

    function automatic void add(logic r, logic e, logic [7:0] c, logic en, logic den,
                                int g, int d);
        vec_t v;
        v.rst = r; v.entry = e; v.cap = c; v.en = en; v.den = den; v.grant = g; v.deny = d;
        vq.push_back(v);
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec=%0d actual=%0d required=%0d", name, idx, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        entry = 1'b0;
        parking_capacity = '0;

        // 1: reset with a car waiting, then release
        add(1, 1, 5, 0, 0, 0, 0);
        add(1, 1, 5, 0, 0, 0, 0);
        add(0, 1, 5, 1, 0, 1, 0);
        add(0, 0, 5, 0, 0, 1, 0);
        // 2: no request while capacity sweeps
        for (int c = 0; c < 8; c++)
            for (int k = 0; k < 10; k++) add(0, 0, 8'(c), 0, 0, 1, 0);
        // 3: request held across the capacity sweep
        add(1, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 8; c++)
            for (int k = 0; k < 10; k++)
                if (c == 0) add(0, 1, 8'(c), 0, 1, 0, 1);
                else        add(0, 1, 8'(c), 1, 0, 0, 1);
        add(0, 0, 7, 0, 0, 0, 1);
        // 4: pulsed requests, full lot then wide-open lot
        add(1, 0, 0, 0, 0, 0, 0);
        for (int p = 1; p <= 3; p++) begin
            add(0, 1, 0, 0, 1, 0, p);
            add(0, 0, 0, 0, 0, 0, p);
        end
        for (int p = 1; p <= 4; p++) begin
            add(0, 0, 255, 0, 0, p - 1, 3);
            add(0, 1, 255, 1, 0, p, 3);
            add(0, 0, 255, 0, 0, p, 3);
        end
        // 5: capacity changes under a held request
        add(1, 0, 2, 0, 0, 0, 0);
        add(0, 1, 2, 1, 0, 1, 0);
        add(0, 1, 2, 1, 0, 1, 0);
        add(0, 1, 0, 0, 1, 1, 0);
        add(0, 1, 0, 0, 1, 1, 0);
        add(0, 1, 1, 1, 0, 1, 0);
        add(0, 0, 1, 0, 0, 1, 0);
        // reset mid-request, then the held request is a fresh arrival
        add(0, 1, 3, 1, 0, 2, 0);
        add(1, 1, 3, 0, 0, 0, 0);
        add(0, 1, 3, 1, 0, 1, 0);
        add(0, 1, 3, 1, 0, 1, 0);

        foreach (vq[i]) begin
            @(negedge clk);
            rst = vq[i].rst;
            entry = vq[i].entry;
            parking_capacity = vq[i].cap;
            @(posedge clk);
            #1;
            chk("enable", i, int'(enable), int'(vq[i].en));
            chk("denied", i, int'(denied), int'(vq[i].den));
            chk("grant_count", i, int'(grant_count), vq[i].grant);
            chk("deny_count", i, int'(deny_count), vq[i].deny);
            chk("exclusive", i, int'(enable & denied), 0);
        end

        // 6: saturation of a 4-bit grant counter over 20 arrivals
        @(negedge clk);
        rst = 1'b1;
        entry = 1'b0;
        parking_capacity = 8'd9;
        @(posedge clk);
        #1;
        chk("sat_reset_grant", 0, int'(s_grant_count), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            entry = 1'b1;
            @(posedge clk);
            #1;
            chk("sat_grant", i, int'(s_grant_count), (i > 15) ? 15 : i);
            chk("sat_deny", i, int'(s_deny_count), 0);
            chk("sat_enable", i, int'(s_enable), 1);
            @(negedge clk);
            entry = 1'b0;
            @(posedge clk);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("sat_hold", 21, int'(s_grant_count), 15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
